// File: rtl/bp_be_dcache_lce_req_mshr.sv
// rtl/bp_be_dcache_lce_req_mshr.sv - D$ LCE request MSHR file: miss tracking, request/ack generation, uc store credits
package bp_be_dcache_lce_req_mshr_pkg;

    typedef enum logic [1:0] {e_bp_inv_cfg, e_bp_single_cce_cfg} bp_params_e;

    localparam int paddr_width_p  = 40;
    localparam int lce_id_width_p = 4;
    localparam int cce_id_width_p = 4;
    localparam int dword_width_p  = 64;
    localparam int lce_assoc_p    = 8;
    localparam int way_w          = $clog2(lce_assoc_p);
    localparam int block_offset_w = 6;

    typedef enum logic [1:0] {e_miss_load, e_miss_store, e_uc_load, e_uc_store} dcache_req_type_e;

    typedef struct packed {
        dcache_req_type_e           msg_type;
        logic [paddr_width_p-1:0]   addr;
        logic [1:0]                 size;
        logic [dword_width_p-1:0]   data;
    } dcache_req_s;

    typedef struct packed {
        logic [way_w-1:0] repl_way;
        logic             dirty;
    } dcache_req_metadata_s;

    typedef enum logic [2:0] {
        e_lce_req_type_rd, e_lce_req_type_wr, e_lce_req_type_uc_rd, e_lce_req_type_uc_wr
    } lce_req_type_e;

    typedef enum logic {e_lce_req_excl, e_lce_req_not_excl} lce_req_non_excl_e;

    typedef struct packed {
        logic [cce_id_width_p-1:0]  dst_id;
        logic [lce_id_width_p-1:0]  src_id;
        lce_req_type_e              msg_type;
        lce_req_non_excl_e          non_exclusive;
        logic [way_w-1:0]           lru_way_id;
        logic                       lru_dirty;
        logic [1:0]                 uc_size;
        logic [paddr_width_p-1:0]   addr;
        logic [dword_width_p-1:0]   data;
    } lce_req_s;

    typedef enum logic [2:0] {
        e_lce_cce_sync_ack, e_lce_cce_inv_ack, e_lce_cce_tr_ack, e_lce_cce_coh_ack
    } lce_resp_type_e;

    typedef struct packed {
        logic [cce_id_width_p-1:0]  dst_id;
        logic [lce_id_width_p-1:0]  src_id;
        lce_resp_type_e             msg_type;
        logic [paddr_width_p-1:0]   addr;
    } lce_resp_s;

    localparam int dcache_req_width_lp          = $bits(dcache_req_s);
    localparam int dcache_req_metadata_width_lp = $bits(dcache_req_metadata_s);
    localparam int lce_cce_req_width_lp         = $bits(lce_req_s);
    localparam int lce_cce_resp_width_lp        = $bits(lce_resp_s);

    // The default config has two CCEs interleaved on the lowest block-address bit
    function automatic logic [cce_id_width_p-1:0] cce_of_block(input bp_params_e cfg, input logic blk_lsb);
        return (cfg == e_bp_inv_cfg) ? {{(cce_id_width_p-1){1'b0}}, blk_lsb} : '0;
    endfunction

endpackage

module bp_be_dcache_lce_req_mshr
    import bp_be_dcache_lce_req_mshr_pkg::*;
#(
    parameter bp_params_e bp_params_p         = e_bp_inv_cfg,
    parameter int         num_mshr_p          = 2,
    parameter int         uc_credits_p        = 4,
    parameter int         timeout_max_limit_p = 4,
    localparam int        mid_w               = (num_mshr_p > 1) ? $clog2(num_mshr_p) : 1
)(
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic [lce_id_width_p-1:0]               lce_id_i,
    input  logic [dcache_req_width_lp-1:0]          cache_req_i,
    input  logic                                    cache_req_v_i,
    output logic                                    cache_req_ready_o,
    input  logic [dcache_req_metadata_width_lp-1:0] cache_req_metadata_i,
    input  logic                                    cache_req_metadata_v_i,
    input  logic                                    data_received_v_i,
    input  logic [mid_w-1:0]                        data_received_id_i,
    input  logic                                    set_tag_wakeup_v_i,
    input  logic [mid_w-1:0]                        set_tag_wakeup_id_i,
    input  logic                                    uncached_data_v_i,
    input  logic [mid_w-1:0]                        uncached_data_id_i,
    input  logic                                    uc_store_done_i,
    input  logic                                    coherence_blocked_i,
    input  logic                                    cmd_ready_i,
    output logic [lce_cce_req_width_lp-1:0]         lce_req_o,
    output logic                                    lce_req_v_o,
    input  logic                                    lce_req_ready_i,
    output logic [lce_cce_resp_width_lp-1:0]        lce_resp_o,
    output logic                                    lce_resp_v_o,
    input  logic                                    lce_resp_yumi_i,
    output logic [num_mshr_p-1:0]                   mshr_busy_o
);

    localparam int to_w = $clog2(timeout_max_limit_p + 1);

    typedef enum logic [1:0] {e_free, e_send, e_sleep, e_ack} mshr_state_e;
    typedef enum logic [1:0] {e_kind_rd, e_kind_wr, e_kind_uc_rd} mshr_kind_e;

    mshr_state_e                r_state  [num_mshr_p];
    mshr_kind_e                 r_kind   [num_mshr_p];
    logic [paddr_width_p-1:0]   r_addr   [num_mshr_p];
    logic [1:0]                 r_size   [num_mshr_p];
    logic                       r_meta_v [num_mshr_p];
    logic [way_w-1:0]           r_way    [num_mshr_p];
    logic                       r_dirty  [num_mshr_p];
    logic                       r_meta_pending;
    logic [mid_w-1:0]           r_meta_id;
    logic [3:0]                 r_uc_cnt;
    logic [mid_w-1:0]           r_rr_ptr;
    logic [to_w-1:0]            r_to_cnt;

    dcache_req_s                w_req_in;
    dcache_req_metadata_s       w_meta_in;
    lce_req_s                   w_req;
    lce_resp_s                  w_resp;
    logic [num_mshr_p-1:0]      w_cand;
    logic                       w_any_free, w_cand_any, w_ack_any, w_timeout;
    logic [mid_w-1:0]           w_free_id, w_send_id, w_ack_id;
    logic                       w_accept, w_uc_st, w_alloc, w_cached, w_send_fire;

    assign w_req_in  = dcache_req_s'(cache_req_i);
    assign w_meta_in = dcache_req_metadata_s'(cache_req_metadata_i);
    assign w_timeout = (r_to_cnt == to_w'(timeout_max_limit_p));

    always_comb begin
        w_any_free  = 1'b0;
        w_free_id   = '0;
        w_ack_any   = 1'b0;
        w_ack_id    = '0;
        w_cand      = '0;
        mshr_busy_o = '0;
        for (int i = num_mshr_p - 1; i >= 0; i--) begin
            mshr_busy_o[i] = (r_state[i] != e_free);
            w_cand[i]      = (r_state[i] == e_send) && (r_meta_v[i] || r_kind[i] == e_kind_uc_rd);
            if (r_state[i] == e_free) begin
                w_any_free = 1'b1;
                w_free_id  = mid_w'(i);
            end
            if (r_state[i] == e_ack) begin
                w_ack_any = 1'b1;
                w_ack_id  = mid_w'(i);
            end
        end
    end

    // Round-robin: the candidate closest at or after the pointer wins
    always_comb begin
        w_cand_any = 1'b0;
        w_send_id  = '0;
        for (int k = num_mshr_p - 1; k >= 0; k--) begin
            if (w_cand[(int'(r_rr_ptr) + k) % num_mshr_p]) begin
                w_cand_any = 1'b1;
                w_send_id  = mid_w'((int'(r_rr_ptr) + k) % num_mshr_p);
            end
        end
    end

    assign cache_req_ready_o = cmd_ready_i & lce_req_ready_i & ~w_timeout & ~r_meta_pending
                             & w_any_free & (r_uc_cnt < 4'(uc_credits_p));
    assign w_accept    = cache_req_v_i & cache_req_ready_o;
    assign w_uc_st     = w_accept & (w_req_in.msg_type == e_uc_store);
    assign w_alloc     = w_accept & (w_req_in.msg_type != e_uc_store);
    assign w_cached    = w_alloc & (w_req_in.msg_type != e_uc_load);
    assign w_send_fire = lce_req_ready_i & ~w_uc_st & w_cand_any;
    assign lce_req_v_o = ~reset_i & (w_uc_st | w_send_fire);

    always_comb begin
        w_req               = '0;
        w_req.src_id        = lce_id_i;
        w_req.non_exclusive = e_lce_req_excl;
        if (w_uc_st) begin
            w_req.dst_id   = cce_of_block(bp_params_p, w_req_in.addr[block_offset_w]);
            w_req.msg_type = e_lce_req_type_uc_wr;
            w_req.addr     = w_req_in.addr;
            w_req.uc_size  = w_req_in.size;
            w_req.data     = w_req_in.data;
        end else begin
            w_req.dst_id = cce_of_block(bp_params_p, r_addr[w_send_id][block_offset_w]);
            w_req.addr   = r_addr[w_send_id];
            case (r_kind[w_send_id])
                e_kind_uc_rd: begin
                    w_req.msg_type = e_lce_req_type_uc_rd;
                    w_req.uc_size  = r_size[w_send_id];
                end
                e_kind_wr: begin
                    w_req.msg_type   = e_lce_req_type_wr;
                    w_req.lru_way_id = r_way[w_send_id];
                    w_req.lru_dirty  = r_dirty[w_send_id];
                end
                default: begin
                    w_req.msg_type   = e_lce_req_type_rd;
                    w_req.lru_way_id = r_way[w_send_id];
                    w_req.lru_dirty  = r_dirty[w_send_id];
                end
            endcase
        end
    end

    always_comb begin
        w_resp          = '0;
        w_resp.dst_id   = cce_of_block(bp_params_p, r_addr[w_ack_id][block_offset_w]);
        w_resp.src_id   = lce_id_i;
        w_resp.msg_type = e_lce_cce_coh_ack;
        w_resp.addr     = r_addr[w_ack_id];
    end

    assign lce_req_o    = w_req;
    assign lce_resp_o   = w_resp;
    assign lce_resp_v_o = w_ack_any;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < num_mshr_p; i++) begin
                r_state[i]  <= e_free;
                r_kind[i]   <= e_kind_rd;
                r_addr[i]   <= '0;
                r_size[i]   <= '0;
                r_meta_v[i] <= 1'b0;
                r_way[i]    <= '0;
                r_dirty[i]  <= 1'b0;
            end
            r_meta_pending <= 1'b0;
            r_meta_id      <= '0;
            r_uc_cnt       <= '0;
            r_rr_ptr       <= '0;
            r_to_cnt       <= '0;
        end else begin
            for (int i = 0; i < num_mshr_p; i++) begin
                case (r_state[i])
                    e_free: if (w_alloc && w_free_id == mid_w'(i)) begin
                        r_state[i]  <= e_send;
                        r_addr[i]   <= w_req_in.addr;
                        r_size[i]   <= w_req_in.size;
                        r_kind[i]   <= (w_req_in.msg_type == e_miss_store) ? e_kind_wr
                                     : (w_req_in.msg_type == e_uc_load)    ? e_kind_uc_rd : e_kind_rd;
                        r_meta_v[i] <= w_cached & cache_req_metadata_v_i;
                        r_way[i]    <= w_meta_in.repl_way;
                        r_dirty[i]  <= w_meta_in.dirty;
                    end
                    e_send: if (w_send_fire && w_send_id == mid_w'(i)) r_state[i] <= e_sleep;
                    e_sleep: begin
                        if ((data_received_v_i && data_received_id_i == mid_w'(i))
                            || (set_tag_wakeup_v_i && set_tag_wakeup_id_i == mid_w'(i)))
                            r_state[i] <= e_ack;
                        else if (uncached_data_v_i && uncached_data_id_i == mid_w'(i))
                            r_state[i] <= e_free;
                    end
                    e_ack: if (lce_resp_yumi_i && w_ack_id == mid_w'(i)) r_state[i] <= e_free;
                    default: r_state[i] <= e_free;
                endcase
                if (r_meta_pending && cache_req_metadata_v_i && r_meta_id == mid_w'(i)) begin
                    r_meta_v[i] <= 1'b1;
                    r_way[i]    <= w_meta_in.repl_way;
                    r_dirty[i]  <= w_meta_in.dirty;
                end
            end

            if (w_cached && !cache_req_metadata_v_i) begin
                r_meta_pending <= 1'b1;
                r_meta_id      <= w_free_id;
            end else if (r_meta_pending && cache_req_metadata_v_i) begin
                r_meta_pending <= 1'b0;
            end

            if (w_send_fire)
                r_rr_ptr <= (w_send_id == mid_w'(num_mshr_p - 1)) ? '0 : w_send_id + mid_w'(1);

            if (w_uc_st && !uc_store_done_i) begin
                r_uc_cnt <= r_uc_cnt + 4'd1;
            end else if (!w_uc_st && uc_store_done_i) begin
                assert (r_uc_cnt != 4'd0) else $error("uc_store_done_i with no uncached store in flight");
                if (r_uc_cnt != 4'd0) r_uc_cnt <= r_uc_cnt - 4'd1;
            end

            if (!coherence_blocked_i) r_to_cnt <= '0;
            else if (!w_timeout)      r_to_cnt <= r_to_cnt + to_w'(1);

            // Stray wakeups are dropped; the state update above already ignores them
            if (data_received_v_i)
                assert (r_state[data_received_id_i] == e_sleep)
                    else $warning("data_received for MSHR %0d not sleeping; ignored", data_received_id_i);
            if (set_tag_wakeup_v_i)
                assert (r_state[set_tag_wakeup_id_i] == e_sleep)
                    else $warning("set_tag_wakeup for MSHR %0d not sleeping; ignored", set_tag_wakeup_id_i);
            if (uncached_data_v_i)
                assert (r_state[uncached_data_id_i] == e_sleep)
                    else $warning("uncached_data for MSHR %0d not sleeping; ignored", uncached_data_id_i);
        end
    end

endmodule

// File: tb/tb_bp_be_dcache_lce_req_mshr.sv
// tb/tb_bp_be_dcache_lce_req_mshr.sv - directed scoreboard bench for bp_be_dcache_lce_req_mshr
module tb_bp_be_dcache_lce_req_mshr;
    import bp_be_dcache_lce_req_mshr_pkg::*;

    localparam int num_mshr_p = 2;
    localparam int mid_w      = 1;

    logic clk_i = 1'b0;
    logic reset_i = 1'b0;
    logic [lce_id_width_p-1:0]               lce_id_i;
    logic [dcache_req_width_lp-1:0]          cache_req_i;
    logic                                    cache_req_v_i;
    logic                                    cache_req_ready_o;
    logic [dcache_req_metadata_width_lp-1:0] cache_req_metadata_i;
    logic                                    cache_req_metadata_v_i;
    logic                                    data_received_v_i;
    logic [mid_w-1:0]                        data_received_id_i;
    logic                                    set_tag_wakeup_v_i;
    logic [mid_w-1:0]                        set_tag_wakeup_id_i;
    logic                                    uncached_data_v_i;
    logic [mid_w-1:0]                        uncached_data_id_i;
    logic                                    uc_store_done_i;
    logic                                    coherence_blocked_i;
    logic                                    cmd_ready_i;
    logic [lce_cce_req_width_lp-1:0]         lce_req_o;
    logic                                    lce_req_v_o;
    logic                                    lce_req_ready_i;
    logic [lce_cce_resp_width_lp-1:0]        lce_resp_o;
    logic                                    lce_resp_v_o;
    logic                                    lce_resp_yumi_i;
    logic [num_mshr_p-1:0]                   mshr_busy_o;

    bp_be_dcache_lce_req_mshr #(
        .bp_params_p(e_bp_inv_cfg), .num_mshr_p(num_mshr_p), .uc_credits_p(2), .timeout_max_limit_p(4)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .lce_id_i(lce_id_i),
        .cache_req_i(cache_req_i), .cache_req_v_i(cache_req_v_i), .cache_req_ready_o(cache_req_ready_o),
        .cache_req_metadata_i(cache_req_metadata_i), .cache_req_metadata_v_i(cache_req_metadata_v_i),
        .data_received_v_i(data_received_v_i), .data_received_id_i(data_received_id_i),
        .set_tag_wakeup_v_i(set_tag_wakeup_v_i), .set_tag_wakeup_id_i(set_tag_wakeup_id_i),
        .uncached_data_v_i(uncached_data_v_i), .uncached_data_id_i(uncached_data_id_i),
        .uc_store_done_i(uc_store_done_i), .coherence_blocked_i(coherence_blocked_i),
        .cmd_ready_i(cmd_ready_i), .lce_req_o(lce_req_o), .lce_req_v_o(lce_req_v_o),
        .lce_req_ready_i(lce_req_ready_i), .lce_resp_o(lce_resp_o), .lce_resp_v_o(lce_resp_v_o),
        .lce_resp_yumi_i(lce_resp_yumi_i), .mshr_busy_o(mshr_busy_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [lce_id_width_p-1:0] own_lce = 4'h5;

    int n_cmp = 0;
    int n_bad = 0;
    lce_req_s  exp_req_q  [$];
    lce_resp_s exp_resp_q [$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic lce_req_s mk_req(input lce_req_type_e t, input logic [paddr_width_p-1:0] a,
                                        input logic [way_w-1:0] w, input logic d, input logic [1:0] sz,
                                        input logic [dword_width_p-1:0] data);
        lce_req_s r;
        r               = '0;
        r.dst_id        = {3'b000, a[6]};
        r.src_id        = own_lce;
        r.msg_type      = t;
        r.non_exclusive = e_lce_req_excl;
        r.lru_way_id    = w;
        r.lru_dirty     = d;
        r.uc_size       = sz;
        r.addr          = a;
        r.data          = data;
        return r;
    endfunction

    function automatic lce_resp_s mk_ack(input logic [paddr_width_p-1:0] a);
        lce_resp_s r;
        r          = '0;
        r.dst_id   = {3'b000, a[6]};
        r.src_id   = own_lce;
        r.msg_type = e_lce_cce_coh_ack;
        r.addr     = a;
        return r;
    endfunction

    task automatic drive_req(input dcache_req_type_e t, input logic [paddr_width_p-1:0] a,
                             input logic [1:0] sz, input logic [dword_width_p-1:0] data);
        dcache_req_s q;
        q.msg_type  = t;
        q.addr      = a;
        q.size      = sz;
        q.data      = data;
        cache_req_i = q;
    endtask

    // Called at a negedge; waits a bounded number of cycles for a request, then scores it
    task automatic pop_req(input string tag);
        int n = 0;
        while (lce_req_v_o !== 1'b1 && n < 20) begin
            tick();
            @(negedge clk_i);
            n++;
        end
        chk({tag, "_v"}, 256'(lce_req_v_o), 256'(1'b1));
        chk({tag, "_q"}, 256'(exp_req_q.size() != 0), 256'(1'b1));
        if (exp_req_q.size() != 0) chk(tag, 256'(lce_req_o), 256'(exp_req_q.pop_front()));
    endtask

    task automatic pop_resp(input string tag);
        int n = 0;
        while (lce_resp_v_o !== 1'b1 && n < 20) begin
            tick();
            @(negedge clk_i);
            n++;
        end
        chk({tag, "_v"}, 256'(lce_resp_v_o), 256'(1'b1));
        chk({tag, "_q"}, 256'(exp_resp_q.size() != 0), 256'(1'b1));
        if (exp_resp_q.size() != 0) chk(tag, 256'(lce_resp_o), 256'(exp_resp_q.pop_front()));
        lce_resp_yumi_i = lce_resp_v_o;
        tick();
        lce_resp_yumi_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [paddr_width_p-1:0] a_ld, a0, a1, a_uc;
        a_ld = 40'h00_8000_1000;
        a0   = 40'h00_8000_2040;
        a1   = 40'h00_8000_3000;
        a_uc = 40'h00_A000_0008;

        lce_id_i = own_lce;
        cache_req_i = '0; cache_req_v_i = 1'b0;
        cache_req_metadata_i = '0; cache_req_metadata_v_i = 1'b0;
        data_received_v_i = 1'b0; data_received_id_i = '0;
        set_tag_wakeup_v_i = 1'b0; set_tag_wakeup_id_i = '0;
        uncached_data_v_i = 1'b0; uncached_data_id_i = '0;
        uc_store_done_i = 1'b0; coherence_blocked_i = 1'b0;
        cmd_ready_i = 1'b1; lce_req_ready_i = 1'b1; lce_resp_yumi_i = 1'b0;

        #1 reset_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_req_v",  256'(lce_req_v_o),       256'(1'b0));
        chk("rst_resp_v", 256'(lce_resp_v_o),      256'(1'b0));
        chk("rst_busy",   256'(mshr_busy_o),       256'(2'b00));
        chk("rst_ready",  256'(cache_req_ready_o), 256'(1'b1));
        tick();
        reset_i = 1'b0;

        // Load miss, metadata one cycle late
        drive_req(e_miss_load, a_ld, 2'd3, 64'h0);
        cache_req_v_i = 1'b1;
        @(negedge clk_i);
        chk("ld_ready", 256'(cache_req_ready_o), 256'(1'b1));
        tick();
        cache_req_v_i = 1'b0;
        cache_req_metadata_v_i = 1'b1;
        cache_req_metadata_i = {3'd3, 1'b1};
        exp_req_q.push_back(mk_req(e_lce_req_type_rd, a_ld, 3'd3, 1'b1, 2'd0, 64'h0));
        @(negedge clk_i);
        chk("ld_meta_wait_v",  256'(lce_req_v_o),       256'(1'b0));
        chk("ld_pending_rdy",  256'(cache_req_ready_o), 256'(1'b0));
        chk("ld_busy",         256'(mshr_busy_o),       256'(2'b01));
        tick();
        cache_req_metadata_v_i = 1'b0;
        @(negedge clk_i);
        pop_req("ld_req");
        tick();
        @(negedge clk_i);
        chk("ld_single_req", 256'(lce_req_v_o), 256'(1'b0));
        data_received_v_i = 1'b1; data_received_id_i = 1'b0;
        set_tag_wakeup_v_i = 1'b1; set_tag_wakeup_id_i = 1'b0;
        tick();
        data_received_v_i = 1'b0; set_tag_wakeup_v_i = 1'b0;
        exp_resp_q.push_back(mk_ack(a_ld));
        @(negedge clk_i);
        pop_resp("ld_ack");
        @(negedge clk_i);
        chk("ld_no_second_ack", 256'(lce_resp_v_o), 256'(1'b0));
        chk("ld_busy_clear",    256'(mshr_busy_o),  256'(2'b00));

        // Two misses, request channel stalled, wakeups in reverse order
        tick();
        drive_req(e_miss_load, a0, 2'd3, 64'h0);
        cache_req_v_i = 1'b1;
        cache_req_metadata_v_i = 1'b1;
        cache_req_metadata_i = {3'd5, 1'b0};
        @(negedge clk_i);
        chk("two_first_ready", 256'(cache_req_ready_o), 256'(1'b1));
        tick();
        drive_req(e_miss_store, a1, 2'd3, 64'h0);
        cache_req_metadata_i = {3'd2, 1'b1};
        exp_req_q.push_back(mk_req(e_lce_req_type_rd, a0, 3'd5, 1'b0, 2'd0, 64'h0));
        exp_req_q.push_back(mk_req(e_lce_req_type_wr, a1, 3'd2, 1'b1, 2'd0, 64'h0));
        @(negedge clk_i);
        chk("two_second_ready", 256'(cache_req_ready_o), 256'(1'b1));
        pop_req("two_req_id0");
        tick();
        cache_req_v_i = 1'b0;
        cache_req_metadata_v_i = 1'b0;
        lce_req_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("two_stall_v", 256'(lce_req_v_o), 256'(1'b0));
            tick();
        end
        lce_req_ready_i = 1'b1;
        @(negedge clk_i);
        chk("two_full_ready", 256'(cache_req_ready_o), 256'(1'b0));
        chk("two_busy",       256'(mshr_busy_o),       256'(2'b11));
        pop_req("two_req_id1");
        tick();
        set_tag_wakeup_v_i = 1'b1; set_tag_wakeup_id_i = 1'b1;
        tick();
        set_tag_wakeup_v_i = 1'b0;
        exp_resp_q.push_back(mk_ack(a1));
        @(negedge clk_i);
        pop_resp("two_ack_id1");
        data_received_v_i = 1'b1; data_received_id_i = 1'b0;
        tick();
        data_received_v_i = 1'b0;
        exp_resp_q.push_back(mk_ack(a0));
        @(negedge clk_i);
        pop_resp("two_ack_id0");
        @(negedge clk_i);
        chk("two_busy_clear", 256'(mshr_busy_o), 256'(2'b00));

        // Uncached store credits (two credits)
        tick();
        drive_req(e_uc_store, 40'h00_9000_0010, 2'd2, 64'h1111_2222_3333_4444);
        cache_req_v_i = 1'b1;
        exp_req_q.push_back(mk_req(e_lce_req_type_uc_wr, 40'h00_9000_0010, 3'd0, 1'b0, 2'd2, 64'h1111_2222_3333_4444));
        @(negedge clk_i);
        pop_req("uc_st0");
        tick();
        drive_req(e_uc_store, 40'h00_9000_0058, 2'd3, 64'h5555_6666_7777_8888);
        exp_req_q.push_back(mk_req(e_lce_req_type_uc_wr, 40'h00_9000_0058, 3'd0, 1'b0, 2'd3, 64'h5555_6666_7777_8888));
        @(negedge clk_i);
        pop_req("uc_st1");
        tick();
        drive_req(e_uc_store, 40'h00_9000_0080, 2'd1, 64'h0000_0000_0000_ABCD);
        @(negedge clk_i);
        chk("uc_credit_ready",  256'(cache_req_ready_o), 256'(1'b0));
        chk("uc_credit_hold_v", 256'(lce_req_v_o),       256'(1'b0));
        uc_store_done_i = 1'b1;
        tick();
        uc_store_done_i = 1'b0;
        exp_req_q.push_back(mk_req(e_lce_req_type_uc_wr, 40'h00_9000_0080, 3'd0, 1'b0, 2'd1, 64'h0000_0000_0000_ABCD));
        @(negedge clk_i);
        pop_req("uc_st2");
        tick();
        cache_req_v_i = 1'b0;
        uc_store_done_i = 1'b1;
        tick();
        drive_req(e_uc_store, 40'h00_9000_00C0, 2'd0, 64'h0000_0000_0000_00EE);
        cache_req_v_i = 1'b1;
        exp_req_q.push_back(mk_req(e_lce_req_type_uc_wr, 40'h00_9000_00C0, 3'd0, 1'b0, 2'd0, 64'h0000_0000_0000_00EE));
        @(negedge clk_i);
        pop_req("uc_st3");
        tick();
        cache_req_v_i = 1'b0;
        uc_store_done_i = 1'b0;
        @(negedge clk_i);
        chk("uc_cnt_hold_ready", 256'(cache_req_ready_o), 256'(1'b1));
        tick();
        drive_req(e_uc_store, 40'h00_9000_0100, 2'd2, 64'h0000_0000_CAFE_F00D);
        cache_req_v_i = 1'b1;
        exp_req_q.push_back(mk_req(e_lce_req_type_uc_wr, 40'h00_9000_0100, 3'd0, 1'b0, 2'd2, 64'h0000_0000_CAFE_F00D));
        @(negedge clk_i);
        pop_req("uc_st4");
        tick();
        cache_req_v_i = 1'b0;
        @(negedge clk_i);
        chk("uc_full_again", 256'(cache_req_ready_o), 256'(1'b0));
        uc_store_done_i = 1'b1;
        tick();
        tick();
        uc_store_done_i = 1'b0;

        // Coherence-blocked timeout
        coherence_blocked_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("to_ready_pre", 256'(cache_req_ready_o), 256'(1'b1));
            tick();
        end
        @(negedge clk_i);
        chk("to_ready_blocked", 256'(cache_req_ready_o), 256'(1'b0));
        coherence_blocked_i = 1'b0;
        tick();
        @(negedge clk_i);
        chk("to_ready_restored", 256'(cache_req_ready_o), 256'(1'b1));

        // Uncached load in flight, then reset mid-cycle
        tick();
        drive_req(e_uc_load, a_uc, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        cache_req_v_i = 1'b1;
        exp_req_q.push_back(mk_req(e_lce_req_type_uc_rd, a_uc, 3'd0, 1'b0, 2'd1, 64'h0));
        tick();
        cache_req_v_i = 1'b0;
        @(negedge clk_i);
        pop_req("uc_ld_req");
        tick();
        @(negedge clk_i);
        chk("uc_ld_sleep_busy", 256'(mshr_busy_o), 256'(2'b01));
        #2 reset_i = 1'b1;
        #1;
        chk("rst_mid_busy",   256'(mshr_busy_o),  256'(2'b00));
        chk("rst_mid_req_v",  256'(lce_req_v_o),  256'(1'b0));
        chk("rst_mid_resp_v", 256'(lce_resp_v_o), 256'(1'b0));
        tick();
        reset_i = 1'b0;
        uncached_data_v_i = 1'b1; uncached_data_id_i = 1'b0;
        tick();
        uncached_data_v_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_busy",   256'(mshr_busy_o),       256'(2'b00));
        chk("post_rst_resp_v", 256'(lce_resp_v_o),      256'(1'b0));
        chk("post_rst_req_v",  256'(lce_req_v_o),       256'(1'b0));
        chk("post_rst_ready",  256'(cache_req_ready_o), 256'(1'b1));

        chk("req_q_empty",  256'(exp_req_q.size()),  256'(0));
        chk("resp_q_empty", 256'(exp_resp_q.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
